stack_sequencer: RTL and testbench

- Multi-cycle sequencer directly upstream of the 8-bit data memory in the RNBIP-2 datapath.
- Owns the stack pointer and executes PUSH, POP, CALL and RET.
- Drives the memory's SP address, write enable, address-mux select (S20) and data-mux select (S50).
- Captures memory read data for POP (to a register) and RET (to the PC).

---
 rtl/stack_sequencer.sv | 221 ++++++++++++++++++++++
 tb/tb_stack_sequencer.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stack_sequencer.sv
// stack_sequencer: owns the stack pointer and sequences PUSH/POP/CALL/RET
// against the data memory (SP address, write enable, S20/S50 mux selects).
// Optional macro STACK_GUARD_EN: depth tracking with sticky overflow/underflow.
module stack_sequencer #(
    parameter logic [7:0]  STACK_BASE  = 8'hFF,
    parameter int unsigned STACK_DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       op_valid,
    input  logic [1:0] op,
    input  logic [7:0] target_in,
    input  logic [7:0] mem_rdata,
    input  logic       clr_err,
    output logic [7:0] sp_out,
    output logic       mem_wr,
    output logic       s20,
    output logic       s50,
    output logic       busy,
    output logic       done,
    output logic       rn_load,
    output logic       pc_load,
    output logic [7:0] data_out,
    output logic       overflow,
    output logic       underflow
);

    localparam int unsigned DW = 8;

    localparam logic [1:0] OP_PUSH = 2'b00;
    localparam logic [1:0] OP_POP  = 2'b01;
    localparam logic [1:0] OP_CALL = 2'b10;
    localparam logic [1:0] OP_RET  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_INC   = 3'd2,
        S_READ  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] sp_q, sp_d;
    logic [DW-1:0] tgt_q, tgt_d;
    logic [DW-1:0] data_out_q, data_out_d;
    logic [1:0]    op_q, op_d;
    logic          err_q, err_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;
    logic          mem_wr_q, mem_wr_d;
    logic          s20_q, s20_d;
    logic          s50_q, s50_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          rn_load_q, rn_load_d;
    logic          pc_load_q, pc_load_d;

`ifdef STACK_GUARD_EN
    logic [DW-1:0] depth_q, depth_d;
    logic          full, empty;

    // Stack occupancy limits
    assign full  = (depth_q == DW'(STACK_DEPTH));
    assign empty = (depth_q == '0);
`else
    logic unused_cfg;
    assign unused_cfg = clr_err | (STACK_DEPTH > 32'd255);
`endif

    // Next-state, SP arithmetic and registered output decode
    always_comb begin
        state_d     = state_q;
        sp_d        = sp_q;
        tgt_d       = tgt_q;
        data_out_d  = data_out_q;
        op_d        = op_q;
        err_d       = err_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        mem_wr_d    = 1'b0;
        s20_d       = 1'b0;
        s50_d       = 1'b0;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        rn_load_d   = 1'b0;
        pc_load_d   = 1'b0;
`ifdef STACK_GUARD_EN
        depth_d     = depth_q;
        if (clr_err) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
`else
        overflow_d  = 1'b0;
        underflow_d = 1'b0;
`endif

        unique case (state_q)
            S_IDLE: begin
                if (op_valid) begin
                    op_d  = op;
                    tgt_d = target_in;
                    err_d = 1'b0;
                    if (!op[0]) begin
`ifdef STACK_GUARD_EN
                        if (full) begin
                            state_d    = S_DONE;
                            err_d      = 1'b1;
                            overflow_d = 1'b1;
                        end else
`endif
                        state_d = S_WRITE;
                    end else begin
`ifdef STACK_GUARD_EN
                        if (empty) begin
                            state_d     = S_DONE;
                            err_d       = 1'b1;
                            underflow_d = 1'b1;
                        end else
`endif
                        state_d = S_INC;
                    end
                end
            end
            S_WRITE: begin
                sp_d    = sp_q - DW'(1);
`ifdef STACK_GUARD_EN
                depth_d = depth_q + DW'(1);
`endif
                state_d = S_DONE;
            end
            S_INC: begin
                sp_d    = sp_q + DW'(1);
`ifdef STACK_GUARD_EN
                depth_d = depth_q - DW'(1);
`endif
                state_d = S_READ;
            end
            S_READ: begin
                data_out_d = mem_rdata;
                state_d    = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are registered, so decode them from the state being entered
        mem_wr_d  = (state_d == S_WRITE);
        s20_d     = (state_d == S_WRITE) || (state_d == S_READ);
        s50_d     = (state_d == S_WRITE) && (op_d == OP_PUSH);
        busy_d    = (state_d != S_IDLE);
        done_d    = (state_d == S_DONE);
        rn_load_d = (state_d == S_DONE) && !err_d && (op_d == OP_POP);
        pc_load_d = (state_d == S_DONE) && !err_d &&
                    ((op_d == OP_CALL) || (op_d == OP_RET));
        if ((state_d == S_DONE) && (state_q == S_WRITE) && (op_d == OP_CALL)) begin
            data_out_d = tgt_d;
        end
    end

    // State, SP and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            sp_q        <= STACK_BASE;
            tgt_q       <= '0;
            data_out_q  <= '0;
            op_q        <= '0;
            err_q       <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            mem_wr_q    <= 1'b0;
            s20_q       <= 1'b0;
            s50_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rn_load_q   <= 1'b0;
            pc_load_q   <= 1'b0;
`ifdef STACK_GUARD_EN
            depth_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            sp_q        <= sp_d;
            tgt_q       <= tgt_d;
            data_out_q  <= data_out_d;
            op_q        <= op_d;
            err_q       <= err_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            mem_wr_q    <= mem_wr_d;
            s20_q       <= s20_d;
            s50_q       <= s50_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            rn_load_q   <= rn_load_d;
            pc_load_q   <= pc_load_d;
`ifdef STACK_GUARD_EN
            depth_q     <= depth_d;
`endif
        end
    end

    assign sp_out    = sp_q;
    assign mem_wr    = mem_wr_q;
    assign s20       = s20_q;
    assign s50       = s50_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign rn_load   = rn_load_q;
    assign pc_load   = pc_load_q;
    assign data_out  = data_out_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_stack_sequencer.sv
// Testbench for stack_sequencer: table of directed operations plus
// hand-written underflow, overflow, busy and mid-operation reset sequences.
module tb_stack_sequencer;

    localparam logic [1:0] OP_PUSH = 2'b00;
    localparam logic [1:0] OP_POP  = 2'b01;
    localparam logic [1:0] OP_CALL = 2'b10;
    localparam logic [1:0] OP_RET  = 2'b11;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       op_valid;
    logic [1:0] op;
    logic [7:0] target_in;
    logic [7:0] mem_rdata;
    logic       clr_err;
    logic [7:0] sp_out;
    logic       mem_wr;
    logic       s20;
    logic       s50;
    logic       busy;
    logic       done;
    logic       rn_load;
    logic       pc_load;
    logic [7:0] data_out;
    logic       overflow;
    logic       underflow;

    // Datapath surroundings: RN, NPC, R0 sources and the data memory
    logic [7:0] rn, npc, r0;
    logic       pre_we;
    logic [7:0] pre_addr, pre_data;
    logic [7:0] mem [256];

    int checks = 0;
    int fails  = 0;

    typedef struct {
        logic [1:0] op;
        logic [7:0] tgt, rn, npc;
        int         lat;
        logic [7:0] wr_tr, s20_tr, wr_addr;
        logic       s50, rn_l, pc_l;
        logic [7:0] dout, sp;
    } vec_t;

    typedef struct {
        int         lat;
        logic [7:0] wr_tr, s20_tr, wr_addr;
        logic       s50, rn_l, pc_l;
        logic [7:0] dout, sp;
        logic       done_after, busy_after;
    } obs_t;

    always #5 clk = ~clk;

    stack_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .op_valid  (op_valid),
        .op        (op),
        .target_in (target_in),
        .mem_rdata (mem_rdata),
        .clr_err   (clr_err),
        .sp_out    (sp_out),
        .mem_wr    (mem_wr),
        .s20       (s20),
        .s50       (s50),
        .busy      (busy),
        .done      (done),
        .rn_load   (rn_load),
        .pc_load   (pc_load),
        .data_out  (data_out),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always @(posedge clk) begin
        if (pre_we) mem[pre_addr] <= pre_data;
        else if (mem_wr) mem[s20 ? sp_out : r0] <= s50 ? rn : npc;
    end

    assign mem_rdata = mem[sp_out];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        op_valid = 1'b0;
        clr_err  = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic preset(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        @(posedge clk); #1;
        pre_we = 1'b0;
    endtask

    // Issue one op and watch it for a bounded number of cycles
    task automatic exec(input logic [1:0] o, input logic [7:0] tgt, output obs_t ob);
        ob = '{default: '0};
        @(negedge clk);
        op = o; target_in = tgt; op_valid = 1'b1;
        @(posedge clk); #1;
        op_valid = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            if (mem_wr) begin
                ob.wr_tr[k] = 1'b1; ob.wr_addr = sp_out; ob.s50 = s50;
            end
            if (s20) ob.s20_tr[k] = 1'b1;
            if (done) begin
                ob.lat = k; ob.rn_l = rn_load; ob.pc_l = pc_load;
                ob.dout = data_out; ob.sp = sp_out;
                break;
            end
            @(posedge clk); #1;
        end
        if (ob.lat != 0) begin
            @(posedge clk); #1;
        end
        ob.done_after = done;
        ob.busy_after = busy;
    endtask

    task automatic check_vec(input string nm, input vec_t v, input obs_t ob);
        chk({nm, "_latency"}, 8'(ob.lat), 8'(v.lat));
        chk({nm, "_wr_trace"}, ob.wr_tr, v.wr_tr);
        chk({nm, "_s20_trace"}, ob.s20_tr, v.s20_tr);
        chk({nm, "_rn_load"}, 8'(ob.rn_l), 8'(v.rn_l));
        chk({nm, "_pc_load"}, 8'(ob.pc_l), 8'(v.pc_l));
        chk({nm, "_data_out"}, ob.dout, v.dout);
        chk({nm, "_sp"}, ob.sp, v.sp);
        chk({nm, "_done_pulse"}, 8'(ob.done_after), 8'h00);
        chk({nm, "_busy_after"}, 8'(ob.busy_after), 8'h00);
        if (v.wr_tr != 8'h00) begin
            chk({nm, "_wr_addr"}, ob.wr_addr, v.wr_addr);
            chk({nm, "_s50"}, 8'(ob.s50), 8'(v.s50));
            chk({nm, "_mem"}, mem[v.wr_addr], v.s50 ? v.rn : v.npc);
        end
    endtask

    vec_t vecs [6];
    vec_t v;
    obs_t ob;
    int   rn_cnt, busy_cnt;
    logic got;

    initial begin
        rst_n = 1'b0; op_valid = 1'b0; op = 2'b00; target_in = 8'h00;
        clr_err = 1'b0; rn = 8'h00; npc = 8'h00; r0 = 8'h00;
        pre_we = 1'b0; pre_addr = 8'h00; pre_data = 8'h00;

        //          op       tgt    rn     npc  lat wr_tr  s20_tr addr   s50   rn_l  pc_l  dout   sp
        vecs[0] = '{OP_PUSH, 8'h00, 8'h5A, 8'h00, 2, 8'h02, 8'h02, 8'hFF, 1'b1, 1'b0, 1'b0, 8'h00, 8'hFE};
        vecs[1] = '{OP_CALL, 8'h80, 8'h00, 8'h21, 2, 8'h02, 8'h02, 8'hFE, 1'b0, 1'b0, 1'b1, 8'h80, 8'hFD};
        vecs[2] = '{OP_RET,  8'h00, 8'h00, 8'h00, 3, 8'h00, 8'h04, 8'h00, 1'b0, 1'b0, 1'b1, 8'h21, 8'hFE};
        vecs[3] = '{OP_PUSH, 8'h00, 8'h3C, 8'h00, 2, 8'h02, 8'h02, 8'hFE, 1'b1, 1'b0, 1'b0, 8'h21, 8'hFD};
        vecs[4] = '{OP_POP,  8'h00, 8'h00, 8'h00, 3, 8'h00, 8'h04, 8'h00, 1'b0, 1'b1, 1'b0, 8'h3C, 8'hFE};
        vecs[5] = '{OP_POP,  8'h00, 8'h00, 8'h00, 3, 8'h00, 8'h04, 8'h00, 1'b0, 1'b1, 1'b0, 8'h5A, 8'hFF};

        // Reset state
        do_reset();
        chk("rst_sp", sp_out, 8'hFF);
        chk("rst_busy", 8'(busy), 8'h00);
        chk("rst_done", 8'(done), 8'h00);
        chk("rst_mem_wr", 8'(mem_wr), 8'h00);
        chk("rst_s20", 8'(s20), 8'h00);
        chk("rst_data_out", data_out, 8'h00);
        chk("rst_flags", {6'b0, overflow, underflow}, 8'h00);

        // Table of directed operations
        for (int i = 0; i < 6; i++) begin
            rn = vecs[i].rn; npc = vecs[i].npc;
            exec(vecs[i].op, vecs[i].tgt, ob);
            check_vec($sformatf("vec%0d", i), vecs[i], ob);
        end

        // POP from reset
        do_reset();
        preset(8'h00, 8'hA5);
`ifdef STACK_GUARD_EN
        v = '{OP_POP, 8'h00, 8'h00, 8'h00, 1, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'hFF};
`else
        v = '{OP_POP, 8'h00, 8'h00, 8'h00, 3, 8'h00, 8'h04, 8'h00, 1'b0, 1'b1, 1'b0, 8'hA5, 8'h00};
`endif
        exec(OP_POP, 8'h00, ob);
        check_vec("pop_empty", v, ob);
`ifdef STACK_GUARD_EN
        chk("underflow_set", 8'(underflow), 8'h01);
        @(negedge clk); clr_err = 1'b1;
        @(posedge clk); #1; clr_err = 1'b0;
        chk("underflow_clr", 8'(underflow), 8'h00);
        @(negedge clk); clr_err = 1'b1; op = OP_POP; op_valid = 1'b1;
        @(posedge clk); #1; clr_err = 1'b0; op_valid = 1'b0;
        chk("underflow_set_wins", 8'(underflow), 8'h01);
        chk("underflow_done", 8'(done), 8'h01);
        @(posedge clk); #1;
`else
        chk("underflow_tied", 8'(underflow), 8'h00);
        chk("overflow_tied", 8'(overflow), 8'h00);
`endif

        // Fill the stack, then one push too many
        do_reset();
        for (int i = 0; i < 16; i++) begin
            rn = 8'(i + 1);
            exec(OP_PUSH, 8'h00, ob);
        end
        chk("fill_sp", sp_out, 8'hEF);
        rn = 8'h77;
`ifdef STACK_GUARD_EN
        v = '{OP_PUSH, 8'h00, 8'h77, 8'h00, 1, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'hEF};
`else
        v = '{OP_PUSH, 8'h00, 8'h77, 8'h00, 2, 8'h02, 8'h02, 8'hEF, 1'b1, 1'b0, 1'b0, 8'h00, 8'hEE};
`endif
        exec(OP_PUSH, 8'h00, ob);
        check_vec("push_full", v, ob);
`ifdef STACK_GUARD_EN
        chk("overflow_set", 8'(overflow), 8'h01);
`else
        chk("overflow_tied2", 8'(overflow), 8'h00);
`endif

        // op_valid held high across a POP: exactly one executes
        do_reset();
        rn = 8'h11;
        exec(OP_PUSH, 8'h00, ob);
        @(negedge clk); op = OP_POP; op_valid = 1'b1;
        rn_cnt = 0; busy_cnt = 0; got = 1'b0;
        for (int k = 1; k <= 8 && !got; k++) begin
            @(posedge clk); #1;
            if (k == 1) chk("held_busy", 8'(busy), 8'h01);
            if (rn_load) rn_cnt++;
            if (done) begin got = 1'b1; op_valid = 1'b0; end
        end
        op_valid = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            if (rn_load) rn_cnt++;
            if (busy) busy_cnt++;
        end
        chk("held_pop_count", 8'(rn_cnt), 8'h01);
        chk("held_idle_after", 8'(busy_cnt), 8'h00);
        chk("held_sp", sp_out, 8'hFF);
        chk("held_data", data_out, 8'h11);

        // Reset asserted during WRITE
        do_reset();
        preset(8'hFF, 8'hEE);
        rn = 8'h99;
        @(negedge clk); op = OP_PUSH; op_valid = 1'b1;
        @(posedge clk); #1; op_valid = 1'b0;
        chk("wr_before_rst", 8'(mem_wr), 8'h01);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_mem_wr", 8'(mem_wr), 8'h00);
        chk("rst_mid_sp", sp_out, 8'hFF);
        chk("rst_mid_busy", 8'(busy), 8'h00);
        chk("rst_mid_s20", 8'(s20), 8'h00);
        @(posedge clk); #1;
        chk("rst_mid_no_write", mem[8'hFF], 8'hEE);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid_done", 8'(done), 8'h00);
        chk("rst_mid_idle", 8'(busy), 8'h00);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
